// File: rtl/fc_pkg.sv
// fc_pkg: FSM state encoding, default widths and the saturation helper
// shared by the fully-connected layer scheduler and its MAC.
package fc_pkg;
  localparam int DW_DEF = 8;
  localparam int OW_DEF = 16;
  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, OUT, FIN} state_t;
  function automatic longint sat(input longint v, input int ow);
    longint hi, lo;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed multiply-accumulate with bias preload; sum exposes the
// accumulator plus the current product so a result can be captured in the same cycle.
module fc_mac
  import fc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 2 * DW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] bias,
  output logic signed [AW-1:0] acc,
  output logic signed [AW-1:0] sum
);
  logic signed [2*DW-1:0] prod;
  assign prod = a * b;
  assign sum  = acc + AW'(prod);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (load) acc <= AW'(bias);
    else if (en) acc <= sum;
endmodule

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: walks N_OUT nodes of a fully-connected layer, streaming
// bias, activations and weights through fc_mac and handing saturated results downstream.
module fc_layer_sched
  import fc_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 200,
  parameter int DW    = DW_DEF,
  parameter int OW    = OW_DEF,
  localparam int IAW  = N_IN > 1 ? $clog2(N_IN) : 1,
  localparam int JW   = N_OUT > 1 ? $clog2(N_OUT) : 1,
  localparam int WW   = N_IN * N_OUT > 1 ? $clog2(N_IN * N_OUT) : 1,
  localparam int AW   = 2 * DW + $clog2(N_IN) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IAW-1:0]       in_addr,
  input  logic signed [DW-1:0] in_data,
  output logic [WW-1:0]        w_addr,
  input  logic signed [DW-1:0] w_data,
  output logic [JW-1:0]        b_addr,
  input  logic signed [DW-1:0] b_data,
  output logic                 rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic [JW-1:0]        out_idx
);
  state_t st;
  logic [JW-1:0] j;
  logic signed [AW-1:0] acc, sum;
  logic load, en;
  // Memory data lags the address by a cycle, so the bias lands in MAC slot 0
  // and the last product arrives in DRAIN.
  assign load = st == MAC && in_addr == '0;
  assign en   = (st == MAC && in_addr != '0) || st == DRAIN;
  fc_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk(clk), .rst_n(rst_n), .load(load), .en(en),
    .a(in_data), .b(w_data), .bias(b_data), .acc(acc), .sum(sum)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      j <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      in_addr <= '0;
      w_addr <= '0;
      b_addr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_idx <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          st <= BIAS;
          j <= '0;
          busy <= 1'b1;
          rd_en <= 1'b1;
          b_addr <= '0;
        end
        BIAS: begin
          st <= MAC;
          in_addr <= '0;
          w_addr <= WW'(int'(j) * N_IN);
        end
        MAC: if (in_addr == IAW'(N_IN - 1)) begin
          st <= DRAIN;
          rd_en <= 1'b0;
        end else begin
          in_addr <= in_addr + 1'b1;
          w_addr <= w_addr + 1'b1;
        end
        DRAIN: begin
          st <= OUT;
          out_valid <= 1'b1;
          out_idx <= j;
          out_data <= OW'(sat(longint'(sum), OW));
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (j == JW'(N_OUT - 1)) begin
            st <= FIN;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            st <= BIAS;
            j <= j + 1'b1;
            b_addr <= j + 1'b1;
            rd_en <= 1'b1;
          end
        end
        FIN: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
endmodule
